// File: rtl/vga_timing_core.sv
// vga_timing_core: runtime-programmable VGA sync/colour generator with frame-boundary shadowed timing
module vga_timing_core #(
    parameter int   CNT_W  = 12,
    parameter int   R_W    = 5,
    parameter int   G_W    = 6,
    parameter int   B_W    = 5,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0
) (
    input  logic                     pixel_clk,
    input  logic                     reset,
    input  logic [CNT_W-1:0]         H_Sync,
    input  logic [CNT_W-1:0]         H_BP,
    input  logic [CNT_W-1:0]         H_FP,
    input  logic [CNT_W-1:0]         H_Range,
    input  logic [CNT_W-1:0]         H_LR_Border,
    input  logic [CNT_W-1:0]         V_Sync,
    input  logic [CNT_W-1:0]         V_BP,
    input  logic [CNT_W-1:0]         V_FP,
    input  logic [CNT_W-1:0]         V_Range,
    input  logic [CNT_W-1:0]         V_TB_Border,
    input  logic [R_W+G_W+B_W-1:0]   InImage_Color,
    input  logic [R_W+G_W+B_W-1:0]   OutImage_Color,
    input  logic                     cfg_load,
    output logic [R_W-1:0]           VGA_R,
    output logic [G_W-1:0]           VGA_G,
    output logic [B_W-1:0]           VGA_B,
    output logic                     VGA_HS,
    output logic                     VGA_VS,
    output logic [CNT_W-1:0]         pix_x,
    output logic [CNT_W-1:0]         pix_y,
    output logic                     active,
    output logic                     frame_start,
    output logic                     line_start,
    output logic                     cfg_err
);
    localparam int TW = CNT_W + 2;
    logic [CNT_W-1:0] s_hsync, s_hbp, s_hfp, s_hr, s_hb, s_vsync, s_vbp, s_vfp, s_vr, s_vb;
    logic [CNT_W-1:0] h_cnt, v_cnt, x, y;
    logic [TW-1:0] h_beg, h_end, h_tot, v_beg, v_end, v_tot;
    logic s_ok, pend, in_ok, h_last, v_last, frame_end, apply, act, border;
    logic [R_W+G_W+B_W-1:0] col;

    always_comb begin
        in_ok = H_Sync != '0 && V_Sync != '0 && H_Range != '0 && V_Range != '0 &&
                {H_LR_Border, 1'b0} <= {1'b0, H_Range} && {V_TB_Border, 1'b0} <= {1'b0, V_Range};
        h_beg = TW'(s_hsync) + TW'(s_hbp);
        h_end = h_beg + TW'(s_hr);
        h_tot = h_end + TW'(s_hfp);
        v_beg = TW'(s_vsync) + TW'(s_vbp);
        v_end = v_beg + TW'(s_vr);
        v_tot = v_end + TW'(s_vfp);
        h_last = TW'(h_cnt) == h_tot - TW'(1);
        v_last = TW'(v_cnt) == v_tot - TW'(1);
        frame_end = s_ok && h_last && v_last;
        // a frozen block has no frame end to wait for, so a pending load goes in immediately
        apply = s_ok ? frame_end && (pend || cfg_load) : pend;
        x = h_cnt - s_hsync - s_hbp;
        y = v_cnt - s_vsync - s_vbp;
        act = s_ok && TW'(h_cnt) >= h_beg && TW'(h_cnt) < h_end && TW'(v_cnt) >= v_beg && TW'(v_cnt) < v_end;
        border = x < s_hb || x >= s_hr - s_hb || y < s_vb || y >= s_vr - s_vb;
        col = act ? (border ? OutImage_Color : InImage_Color) : '0;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset || (apply && in_ok)) begin
            s_hsync <= H_Sync;
            s_hbp   <= H_BP;
            s_hfp   <= H_FP;
            s_hr    <= H_Range;
            s_hb    <= H_LR_Border;
            s_vsync <= V_Sync;
            s_vbp   <= V_BP;
            s_vfp   <= V_FP;
            s_vr    <= V_Range;
            s_vb    <= V_TB_Border;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s_ok    <= in_ok;
            cfg_err <= !in_ok;
            pend    <= 1'b0;
        end else begin
            pend <= !apply && (pend || cfg_load);
            if (apply) begin
                s_ok    <= s_ok || in_ok;
                cfg_err <= !in_ok;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset || !s_ok || frame_end) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge pixel_clk) begin
        VGA_HS              <= (!reset && s_ok && h_cnt < s_hsync) ? HS_POL : ~HS_POL;
        VGA_VS              <= (!reset && s_ok && v_cnt < s_vsync) ? VS_POL : ~VS_POL;
        {VGA_R, VGA_G, VGA_B} <= reset ? '0 : col;
        pix_x               <= (!reset && act) ? x : '0;
        pix_y               <= (!reset && act) ? y : '0;
        active              <= !reset && act;
        line_start          <= !reset && s_ok && h_cnt == '0;
        frame_start         <= !reset && s_ok && h_cnt == '0 && v_cnt == '0;
    end
endmodule
